// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the control unit and data memory.
// The master issues single-cycle requests; the slave reports BUSY/DONE/ERR.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] DMADDR;
  logic [DATA_W-1:0] DMDIN;
  logic              MEM_RD;
  logic              MEM_WR;
  logic [DATA_W-1:0] DMDOUT;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output DMADDR,
    output DMDIN,
    output MEM_RD,
    output MEM_WR,
    input  DMDOUT,
    input  BUSY,
    input  DONE,
    input  ERR
  );

  modport slave (
    input  DMADDR,
    input  DMDIN,
    input  MEM_RD,
    input  MEM_WR,
    output DMDOUT,
    output BUSY,
    output DONE,
    output ERR
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with a fixed-latency access controller.
// Requests are latched in IDLE and completed LATENCY edges later.
module data_memory_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                RST,
  data_memory_ctrl_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic req_any;
  logic req_both;
  logic in_range;
  logic cnt_last;

  assign req_any  = bus.MEM_RD ^ bus.MEM_WR;
  assign req_both = bus.MEM_RD & bus.MEM_WR;
  assign in_range = {1'b0, bus.DMADDR} < DEPTH_L;
  assign cnt_last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_both) begin
          err_d = 1'b1;
        end else if (req_any) begin
          if (in_range) begin
            addr_d  = bus.DMADDR[AW-1:0];
            data_d  = bus.DMDIN;
            wr_d    = bus.MEM_WR;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
            state_d = ACCESS;
          end else begin
            // Out-of-range is rejected, never truncated into the array
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!cnt_last) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem[addr_q];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; RST only suppresses a pending write
  always_ff @(posedge clk) begin
    if (!RST && mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  assign bus.DMDOUT = dout_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.ERR    = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl at LATENCY=2, DEPTH=256.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_data_memory_ctrl;

  logic clk;
  logic RST;
  int   total;
  int   passed;

  data_memory_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  data_memory_ctrl #(
    .ADDR_W(16),
    .DATA_W(16),
    .DEPTH(256),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.MEM_RD = 1'b0;
    bus.MEM_WR = 1'b0;
  endtask

  // Issue one request and return sampled in its DONE cycle
  task automatic access(input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
    bus.DMADDR = a;
    bus.DMDIN  = d;
    bus.MEM_WR = wr;
    bus.MEM_RD = ~wr;
    step();
    idle_in();
    step();
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.DMADDR = 16'($urandom);
      bus.DMDIN  = 16'($urandom);
      bus.MEM_RD = 1'($urandom_range(0, 1));
      bus.MEM_WR = 1'($urandom_range(0, 1));
      step();
    end
    total++;
    if (bus.DMDOUT !== 16'h0) $display("FAIL rst_dout: got %h want 0000", bus.DMDOUT);
    else passed++;
    total++;
    if ({bus.BUSY, bus.DONE, bus.ERR} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000", {bus.BUSY, bus.DONE, bus.ERR});
    else passed++;
    RST = 1'b0;
    idle_in();
    step();
    step();
    total++;
    if ({bus.DMDOUT, bus.BUSY, bus.DONE, bus.ERR} !== 19'h0)
      $display("FAIL idle_outs: got %h want 00000",
               {bus.DMDOUT, bus.BUSY, bus.DONE, bus.ERR});
    else passed++;
  endtask

  task automatic test_write_read();
    bus.DMADDR = 16'h0005;
    bus.DMDIN  = 16'hBEEF;
    bus.MEM_WR = 1'b1;
    step();
    idle_in();
    total++;
    if ({bus.BUSY, bus.DONE} !== 2'b10)
      $display("FAIL wr_busy1: got %b want 10", {bus.BUSY, bus.DONE});
    else passed++;
    step();
    total++;
    if ({bus.BUSY, bus.DONE} !== 2'b10)
      $display("FAIL wr_busy2: got %b want 10", {bus.BUSY, bus.DONE});
    else passed++;
    step();
    total++;
    if ({bus.BUSY, bus.DONE} !== 2'b01)
      $display("FAIL wr_done: got %b want 01", {bus.BUSY, bus.DONE});
    else passed++;
    step();
    total++;
    if (bus.DONE !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", bus.DONE);
    else passed++;
    access(1'b0, 16'h0005, 16'h0);
    total++;
    if (bus.DONE !== 1'b1 || bus.DMDOUT !== 16'hBEEF)
      $display("FAIL rd_5: got done=%b dout=%h want 1 BEEF", bus.DONE, bus.DMDOUT);
    else passed++;
    step();
    step();
    total++;
    if (bus.DONE !== 1'b0 || bus.DMDOUT !== 16'hBEEF)
      $display("FAIL rd_hold: got done=%b dout=%h want 0 BEEF", bus.DONE, bus.DMDOUT);
    else passed++;
  endtask

  task automatic test_input_change();
    access(1'b1, 16'h0011, 16'h5A5A);
    step();
    bus.DMADDR = 16'h0010;
    bus.DMDIN  = 16'h1234;
    bus.MEM_WR = 1'b1;
    step();
    bus.MEM_WR = 1'b0;
    bus.MEM_RD = 1'b1;
    bus.DMADDR = 16'h0011;
    bus.DMDIN  = 16'hFFFF;
    step();
    bus.MEM_RD = 1'b0;
    step();
    total++;
    if (bus.DONE !== 1'b1) $display("FAIL chg_done: got %b want 1", bus.DONE);
    else passed++;
    step();
    step();
    total++;
    if ({bus.BUSY, bus.DONE} !== 2'b00)
      $display("FAIL chg_no_extra: got %b want 00", {bus.BUSY, bus.DONE});
    else passed++;
    access(1'b0, 16'h0010, 16'h0);
    total++;
    if (bus.DMDOUT !== 16'h1234) $display("FAIL chg_rd10: got %h want 1234", bus.DMDOUT);
    else passed++;
    step();
    access(1'b0, 16'h0011, 16'h0);
    total++;
    if (bus.DMDOUT !== 16'h5A5A) $display("FAIL chg_rd11: got %h want 5A5A", bus.DMDOUT);
    else passed++;
    step();
  endtask

  task automatic test_errors();
    access(1'b1, 16'h0000, 16'h0F0F);
    step();
    bus.DMADDR = 16'h0003;
    bus.MEM_RD = 1'b1;
    bus.MEM_WR = 1'b1;
    step();
    idle_in();
    total++;
    if ({bus.ERR, bus.BUSY, bus.DONE} !== 3'b100)
      $display("FAIL err_both: got %b want 100", {bus.ERR, bus.BUSY, bus.DONE});
    else passed++;
    total++;
    if (bus.DMDOUT !== 16'h5A5A) $display("FAIL err_dout: got %h want 5A5A", bus.DMDOUT);
    else passed++;
    step();
    total++;
    if ({bus.ERR, bus.BUSY, bus.DONE} !== 3'b000)
      $display("FAIL err_pulse: got %b want 000", {bus.ERR, bus.BUSY, bus.DONE});
    else passed++;
    bus.DMADDR = 16'h0100;
    bus.DMDIN  = 16'hDEAD;
    bus.MEM_WR = 1'b1;
    step();
    idle_in();
    total++;
    if ({bus.ERR, bus.BUSY} !== 2'b10)
      $display("FAIL err_range: got %b want 10", {bus.ERR, bus.BUSY});
    else passed++;
    step();
    step();
    total++;
    if ({bus.ERR, bus.BUSY, bus.DONE} !== 3'b000)
      $display("FAIL err_range_quiet: got %b want 000", {bus.ERR, bus.BUSY, bus.DONE});
    else passed++;
    access(1'b0, 16'h0000, 16'h0);
    total++;
    if (bus.DMDOUT !== 16'h0F0F) $display("FAIL err_rd0: got %h want 0F0F", bus.DMDOUT);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    access(1'b1, 16'h0020, 16'h0BAD);
    step();
    bus.DMADDR = 16'h0020;
    bus.DMDIN  = 16'hAAAA;
    bus.MEM_WR = 1'b1;
    step();
    idle_in();
    RST = 1'b1;
    step();
    total++;
    if ({bus.BUSY, bus.DONE, bus.DMDOUT} !== 18'h0)
      $display("FAIL rstmid_flags: got %h want 00000", {bus.BUSY, bus.DONE, bus.DMDOUT});
    else passed++;
    RST = 1'b0;
    step();
    step();
    total++;
    if ({bus.BUSY, bus.DONE} !== 2'b00)
      $display("FAIL rstmid_nodone: got %b want 00", {bus.BUSY, bus.DONE});
    else passed++;
    access(1'b0, 16'h0020, 16'h0);
    total++;
    if (bus.DMDOUT !== 16'h0BAD) $display("FAIL rstmid_rd20: got %h want 0BAD", bus.DMDOUT);
    else passed++;
    step();
    access(1'b0, 16'h0005, 16'h0);
    total++;
    if (bus.DMDOUT !== 16'hBEEF) $display("FAIL rstmid_rd5: got %h want BEEF", bus.DMDOUT);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    access(1'b1, 16'h0001, 16'h1111);
    step();
    access(1'b1, 16'h0002, 16'h2222);
    step();
    access(1'b0, 16'h0001, 16'h0);
    total++;
    if (bus.DONE !== 1'b1 || bus.DMDOUT !== 16'h1111)
      $display("FAIL b2b_rd1: got done=%b dout=%h want 1 1111", bus.DONE, bus.DMDOUT);
    else passed++;
    bus.DMADDR = 16'h0002;
    bus.MEM_RD = 1'b1;
    step();
    idle_in();
    total++;
    if ({bus.BUSY, bus.DONE} !== 2'b10)
      $display("FAIL b2b_accept: got %b want 10", {bus.BUSY, bus.DONE});
    else passed++;
    step();
    total++;
    if (bus.DONE !== 1'b0) $display("FAIL b2b_gap: got %b want 0", bus.DONE);
    else passed++;
    step();
    total++;
    if (bus.DONE !== 1'b1 || bus.DMDOUT !== 16'h2222)
      $display("FAIL b2b_rd2: got done=%b dout=%h want 1 2222", bus.DONE, bus.DMDOUT);
    else passed++;
    step();
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    RST        = 1'b1;
    bus.DMADDR = '0;
    bus.DMDIN  = '0;
    bus.MEM_RD = 1'b0;
    bus.MEM_WR = 1'b0;
    test_reset();
    test_write_read();
    test_input_change();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Word-addressed data memory with its own access controller. It is the consumer of the 16-bit data-memory address (DMADDR) driven by the address register.
- It accepts a read or write request, latches address and write data, and waits a programmable access latency.
- It then performs the access, returns read data and pulses a completion flag.
- The processor control unit stalls on BUSY and advances on DONE.

Parameters:
- ADDR_W, 16, width of DMADDR.
- DATA_W, 16, data word width.
- DEPTH, 256, number of words implemented (valid addresses 0..DEPTH-1).
- LATENCY, 2, cycles from request acceptance to completion; must be >=1.

Ports:
- clk  input  1  clock, all logic on rising edge
- RST  input  1  synchronous active-high reset
- DMADDR  input  ADDR_W  word address from the address register
- DMDIN  input  DATA_W  write data from the data register
- MEM_RD  input  1  read request
- MEM_WR  input  1  write request
- DMDOUT  output  DATA_W  read data
- BUSY  output  1  access in progress
- DONE  output  1  one-cycle completion pulse
- ERR  output  1  one-cycle error pulse

Behaviour:
- Reset: RST is synchronous, active-high; clock is clk. RST=1 at a rising edge forces:
  - state IDLE, latency counter 0;
  - DMDOUT=0, BUSY=0, DONE=0, ERR=0;
  - latched address/data/op cleared.
- The storage array is NOT cleared by RST.
- RST mid-access aborts the access: no write occurs and no DONE is produced.
- State machine: two states, IDLE and ACCESS.
- IDLE, request accepted at edge E0 when exactly one of MEM_RD/MEM_WR is 1 and DMADDR < DEPTH:
  - latch DMADDR, DMDIN and op;
  - counter <= LATENCY-1, BUSY <= 1;
  - go to ACCESS.
- IDLE, both MEM_RD and MEM_WR = 1 at an edge:
  - request rejected, ERR=1 for the next cycle;
  - stay IDLE, no access, DMDOUT unchanged.
- IDLE, single request with DMADDR >= DEPTH:
  - rejected, ERR=1 for one cycle, stay IDLE;
  - no write; DMDOUT unchanged.
- ACCESS, counter != 0: decrement the counter; requests are ignored.
- ACCESS, counter == 0 at an edge:
  - read: DMDOUT <= mem[latched addr];
  - write: mem[latched addr] <= latched data, DMDOUT unchanged;
  - DONE <= 1, BUSY <= 0, go to IDLE.
- Timing: DONE and the new DMDOUT are visible in the cycle following edge E0+LATENCY. BUSY is high in the cycles between edges E0 and E0+LATENCY.
- Back-to-back: IDLE may accept a new request at the edge that ends the DONE cycle. Sustained throughput is one access per LATENCY+1 cycles.
- DONE and ERR are single-cycle pulses and are never high simultaneously.
- DMDOUT holds the last read result until the next completed read.
- Requests need not be held after acceptance. DMADDR/DMDIN changes during ACCESS have no effect, because inputs are latched.
- Address is compared as unsigned. No wrap-around: out-of-range addresses are rejected, never truncated.

Test Plan:
1. Reset: assert RST 2 cycles with random inputs -> DMDOUT=0, BUSY=0, DONE=0, ERR=0; then idle with no request -> outputs remain 0.
2. Write/read, LATENCY=2:
   - MEM_WR=1, DMADDR=0x0005, DMDIN=0xBEEF for 1 cycle -> BUSY=1 for 2 cycles, then DONE pulse.
   - MEM_RD=1, DMADDR=0x0005 -> DONE 2 cycles after acceptance with DMDOUT=0xBEEF, held afterwards.
3. Input change during access: write 0x1234 to addr 0x0010, then change DMADDR=0x0011 and DMDIN=0xFFFF the cycle after acceptance -> reading 0x0010 returns 0x1234 and reading 0x0011 returns its prior value. MEM_RD pulsed while BUSY is ignored (no extra DONE).
4. Errors:
   - MEM_RD=MEM_WR=1 -> ERR one cycle, no BUSY, no DONE.
   - MEM_WR with DMADDR=0x0100 (DEPTH=256) -> ERR; a later read of addr 0x0000 is unaffected.
5. Reset mid-access: start a write of 0xAAAA to addr 0x0020 and assert RST on the cycle after acceptance -> no DONE, BUSY=0; a later read of 0x0020 returns the old value. The storage array retains data written before the RST.
6. Back-to-back reads of 0x0001 (0x1111) and 0x0002 (0x2222), second request presented in the DONE cycle -> DONE pulses spaced LATENCY+1=3 cycles apart, DMDOUT=0x1111 then 0x2222.
